ray_dispatcher: RTL

Hardware raster front-end for `ray_unit`. On `start` it walks a full frame in raster order and presents each pixel's `(x, y)` to `ray_unit` as Q11.21 `screen_x`/`screen_y` with a one-cycle valid pulse. It waits for that ray's `valid_out`, then emits one 8-bit grayscale pixel (hit→255, miss→0) on a stream interface towards the framebuffer/VDMA. Only one ray is outstanding at a time, matching `ray_unit`'s single-request behaviour.

---
 rtl/ray_dispatcher_pkg.sv | 29 ++
 rtl/common_defs.svh | 8 +
 rtl/ray_dispatcher_raster_counter.sv | 37 +++
 rtl/ray_dispatcher.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ray_dispatcher_pkg.sv
// Types and helpers for the raster front-end that feeds ray_unit.
package ray_dispatcher_pkg;

    `include "common_defs.svh"

    localparam int unsigned FRAC_SCREEN = FP_FRAC;
    localparam int unsigned COORD_W     = 10;

    localparam logic [7:0] PIX_HIT  = 8'hFF;
    localparam logic [7:0] PIX_MISS = 8'h00;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT
    } state_t;

    // Integer pixel coordinate placed in the integer field of a Q11.21 word.
    function automatic fp coord_to_fp(input coord_t c);
        logic [31:0] w;
        w = '0;
        w[FRAC_SCREEN +: COORD_W] = c;
        return fp'(w);
    endfunction

endpackage

// File: rtl/common_defs.svh
// Shared fixed-point definitions: Q11.21 coordinate type used across the ray pipeline.
`ifndef COMMON_DEFS_SVH
`define COMMON_DEFS_SVH

typedef logic signed [31:0] fp;
localparam int unsigned FP_FRAC = 21;

`endif

// File: rtl/ray_dispatcher_raster_counter.sv
// Raster-order (x, y) walker with end-of-line, start-of-frame and end-of-frame flags.
module raster_counter
    import ray_dispatcher_pkg::*;
#(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   advance,
    output coord_t x,
    output coord_t y,
    output logic   eol,
    output logic   sof,
    output logic   last
);

    assign eol  = (x == coord_t'(H_RES - 1));
    assign sof  = (x == '0) && (y == '0);
    assign last = eol && (y == coord_t'(V_RES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= last ? '0 : y + coord_t'(1);
            end else begin
                x <= x + coord_t'(1);
            end
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Walks a frame in raster order, issues one ray at a time to ray_unit and streams grayscale pixels.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err,
    output fp          screen_x,
    output fp          screen_y,
    output logic       ray_valid,
    input  logic       ray_done,
    input  logic       ray_hit,
    output logic [7:0] pix_tdata,
    output logic       pix_tvalid,
    input  logic       pix_tready,
    output logic       pix_tuser,
    output logic       pix_tlast
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    state_t          state;
    logic [WD_W-1:0] wdog;
    coord_t          x;
    coord_t          y;
    logic            eol;
    logic            sof;
    logic            last;
    logic            frame_clear;
    logic            advance;

    assign frame_clear = (state == ST_IDLE) && start;
    assign advance     = (state == ST_EMIT) && pix_tready;

    raster_counter #(
        .H_RES(H_RES),
        .V_RES(V_RES)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clear  (frame_clear),
        .advance(advance),
        .x      (x),
        .y      (y),
        .eol    (eol),
        .sof    (sof),
        .last   (last)
    );

    // Coordinates come straight off the raster registers, so they stay put until the next advance.
    assign screen_x = coord_to_fp(x);
    assign screen_y = coord_to_fp(y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wdog        <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            ray_valid   <= 1'b0;
            pix_tdata   <= '0;
            pix_tvalid  <= 1'b0;
            pix_tuser   <= 1'b0;
            pix_tlast   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        ray_valid   <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ray_valid <= 1'b0;
                    wdog      <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ray_done) begin
                        pix_tdata  <= ray_hit ? PIX_HIT : PIX_MISS;
                        pix_tvalid <= 1'b1;
                        pix_tuser  <= sof;
                        pix_tlast  <= eol;
                        state      <= ST_EMIT;
                    end else if (wdog == WD_LIMIT) begin
                        pix_tdata   <= PIX_MISS;
                        pix_tvalid  <= 1'b1;
                        pix_tuser   <= sof;
                        pix_tlast   <= eol;
                        timeout_err <= 1'b1;
                        state       <= ST_EMIT;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (pix_tready) begin
                        pix_tvalid <= 1'b0;
                        pix_tuser  <= 1'b0;
                        pix_tlast  <= 1'b0;
                        if (last) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            ray_valid <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
